lsu_ecc_scrub: RTL
==================

// Module: lsu_ecc_scrub
// PURPOSE
//  Downstream of the DCCM ECC check stage. Captures SEC-corrected DCCM words
//  flagged in DC3 and writes them, with freshly encoded ECC, back to DCCM.
//  Hi and lo banks are handled independently, and writes are arbitrated against
//  store-buffer drain via a req/gnt handshake.
//  Also keeps a saturating count of scrubbed words and a sticky overflow flag.
// PARAMETERS
//  DCCM_BITS   16  DCCM byte-address width
//  DATA_WIDTH  32  DCCM bank data width
//  ECC_WIDTH    7  DCCM bank ECC width
//  CNT_WIDTH   16  scrub counter width
// PORTS
//  clk                      in   1           core clock
//  rst_l                    in   1           reset, synchronous, active-low
//  lsu_single_ecc_err_hi_dc3 in  1           SEC on hi bank this cycle
//  lsu_single_ecc_err_lo_dc3 in  1           SEC on lo bank this cycle
//  lsu_double_ecc_error_dc3 in   1           DED on either bank; suppresses capture
//  dec_tlu_core_ecc_disable in   1           1: ignore new errors (in-flight finishes)
//  lsu_addr_dc3             in   DCCM_BITS   start address (lo bank word)
//  end_addr_dc3             in   DCCM_BITS   end address (hi bank word)
//  store_ecc_datafn_hi_dc3  in   DATA_WIDTH  corrected/merged hi word
//  store_ecc_datafn_lo_dc3  in   DATA_WIDTH  corrected/merged lo word
//  scrub_gnt                in   1           DCCM write port granted this cycle
//  scrub_req                out  1           request DCCM write
//  scrub_wr_addr            out  DCCM_BITS   word-aligned write address ([1:0]=0)
//  scrub_wr_data            out  DATA_WIDTH  write data
//  scrub_wr_ecc             out  ECC_WIDTH   ECC of scrub_wr_data (rvecc_encode)
//  lsu_ecc_scrub_busy       out  1           state != IDLE; decode stalls DCCM accesses
//  lsu_ecc_scrub_cnt        out  CNT_WIDTH   words scrubbed, saturating
//  lsu_ecc_scrub_ovf        out  1           sticky: error dropped while busy
// BEHAVIOUR
//  Reset: state=IDLE. scrub_req, busy, cnt, ovf, and the pending hi/lo flags
//   are all 0. Addr/data registers are also 0. Reset mid-write abandons the write.
//  cap_lo = err_lo & ~double & ~ecc_disable; cap_hi analogous with err_hi.
//  FSM:
//   IDLE  : if cap_lo|cap_hi, register lo word (addr=lsu_addr_dc3 & ~3) and
//           hi word (addr=end_addr_dc3 & ~3), plus the pend_lo/pend_hi flags.
//           Next state is WR_LO if cap_lo, else WR_HI.
//   WR_LO : scrub_req=1 with lo addr/data. On gnt: pend_lo<=0, cnt+=1.
//           Next is WR_HI if pend_hi, else IDLE. Without gnt, hold all outputs.
//   WR_HI : same, using hi addr/data and pend_hi. On gnt: next IDLE.
//  Latency: error in DC3 at cycle N gives scrub_req at N+1. Write happens
//   in the first cycle with scrub_gnt=1. Both banks take at least 2 granted
//   cycles (lo then hi).
//  req/gnt: req and addr/data/ecc stay stable until gnt. gnt without req is
//   ignored. gnt is sampled only in WR_LO/WR_HI.
//  busy = (state!=IDLE), registered. It deasserts the cycle after the last gnt.
//   No capture occurs while busy, including the last-gnt cycle.
//  Error qualifies (cap_*) while busy: drop it and set ovf<=1. ovf clears only
//   on reset.
//  ECC is encoded combinationally from the muxed write data, using a single
//   rvecc_encode instance.
//  Counter saturates at all ones. Two gnts always fall in different cycles,
//   so the increment is at most 1 per cycle.
//  double and single in the same cycle: capture nothing, no ovf.
//  ecc_disable rising while busy: current sequence completes normally.
// TESTING
//  T1: err_lo=1, lsu_addr=0x0106, datafn_lo=0xDEADBEEF, gnt=1 ->
//      cycle+1 req, addr 0x0104, data 0xDEADBEEF, ecc=encode(data).
//      Cycle+2 busy=0, cnt=1.
//  T2: err_hi=err_lo=1, addr 0x0006/end 0x0009, gnt low for 3 cycles then high ->
//      lo write to 0x0004, then hi write to 0x0008 next gnt cycle.
//      cnt=2; outputs stable while waiting.
//  T3: err_lo=1 with double=1, or with ecc_disable=1 -> req never asserts,
//      cnt=0, ovf=0.
//  T4: second err_lo while in WR_LO without gnt -> ovf=1, first write unaffected,
//      no second write, cnt=1.
//  T5: cnt preloaded near max via 2^CNT_WIDTH+1 scrubs -> cnt holds at all ones.
//  T6: rst_l=0 during WR_HI with req=1 -> next cycle req=0, busy=0, cnt=0,
//      ovf=0. A fresh error then is serviced normally.

Source files
------------

// File: rtl/lsu_ecc_scrub.sv
// DCCM ECC scrubber: captures SEC-corrected words flagged in DC3 and writes
// them back (lo bank first, then hi bank) with freshly encoded ECC, using a
// req/gnt handshake against store-buffer drain. Also counts scrubbed words
// (saturating) and records dropped errors in a sticky overflow flag.

module rvecc_encode (
    input  logic [31:0] din,
    output logic [6:0]  ecc_out
);
    logic [5:0] ham;

    // Hamming check bits over positions 1..38 plus overall parity for DED
    always_comb begin
        ham[0]  = ^(din & 32'h56AAAD5B);
        ham[1]  = ^(din & 32'h9B33366D);
        ham[2]  = ^(din & 32'hE3C3C78E);
        ham[3]  = ^(din & 32'h03FC07F0);
        ham[4]  = ^(din & 32'h03FFF800);
        ham[5]  = ^(din & 32'hFC000000);
        ecc_out = {(^din) ^ (^ham), ham};
    end
endmodule

module lsu_ecc_scrub #(
    parameter int unsigned DCCM_BITS  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ECC_WIDTH  = 7,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  lsu_single_ecc_err_hi_dc3,
    input  logic                  lsu_single_ecc_err_lo_dc3,
    input  logic                  lsu_double_ecc_error_dc3,
    input  logic                  dec_tlu_core_ecc_disable,
    input  logic [DCCM_BITS-1:0]  lsu_addr_dc3,
    input  logic [DCCM_BITS-1:0]  end_addr_dc3,
    input  logic [DATA_WIDTH-1:0] store_ecc_datafn_hi_dc3,
    input  logic [DATA_WIDTH-1:0] store_ecc_datafn_lo_dc3,
    input  logic                  scrub_gnt,
    output logic                  scrub_req,
    output logic [DCCM_BITS-1:0]  scrub_wr_addr,
    output logic [DATA_WIDTH-1:0] scrub_wr_data,
    output logic [ECC_WIDTH-1:0]  scrub_wr_ecc,
    output logic                  lsu_ecc_scrub_busy,
    output logic [CNT_WIDTH-1:0]  lsu_ecc_scrub_cnt,
    output logic                  lsu_ecc_scrub_ovf
);
    typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

    state_t                state_q, state_d;
    logic [DCCM_BITS-1:0]  lo_addr_q, lo_addr_d, hi_addr_q, hi_addr_d;
    logic [DATA_WIDTH-1:0] lo_data_q, lo_data_d, hi_data_q, hi_data_d;
    logic                  pend_lo_q, pend_lo_d, pend_hi_q, pend_hi_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  cap_lo, cap_hi, wr_done;

    // Capture qualification, sequencing of lo/hi writes, counter and overflow
    always_comb begin
        state_d   = state_q;
        lo_addr_d = lo_addr_q;
        hi_addr_d = hi_addr_q;
        lo_data_d = lo_data_q;
        hi_data_d = hi_data_q;
        pend_lo_d = pend_lo_q;
        pend_hi_d = pend_hi_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        wr_done   = 1'b0;
        cap_lo    = lsu_single_ecc_err_lo_dc3 & ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable;
        cap_hi    = lsu_single_ecc_err_hi_dc3 & ~lsu_double_ecc_error_dc3 & ~dec_tlu_core_ecc_disable;

        unique case (state_q)
            IDLE: begin
                if (cap_lo | cap_hi) begin
                    lo_addr_d = {lsu_addr_dc3[DCCM_BITS-1:2], 2'b00};
                    hi_addr_d = {end_addr_dc3[DCCM_BITS-1:2], 2'b00};
                    lo_data_d = store_ecc_datafn_lo_dc3;
                    hi_data_d = store_ecc_datafn_hi_dc3;
                    pend_lo_d = cap_lo;
                    pend_hi_d = cap_hi;
                    state_d   = cap_lo ? WR_LO : WR_HI;
                end
            end
            WR_LO: begin
                if (scrub_gnt) begin
                    pend_lo_d = 1'b0;
                    wr_done   = 1'b1;
                    state_d   = pend_hi_q ? WR_HI : IDLE;
                end
            end
            WR_HI: begin
                if (scrub_gnt) begin
                    pend_hi_d = 1'b0;
                    wr_done   = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && (cap_lo | cap_hi)) ovf_d = 1'b1;
        if (wr_done && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            lo_addr_q <= '0;
            hi_addr_q <= '0;
            lo_data_q <= '0;
            hi_data_q <= '0;
            pend_lo_q <= 1'b0;
            pend_hi_q <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_addr_q <= lo_addr_d;
            hi_addr_q <= hi_addr_d;
            lo_data_q <= lo_data_d;
            hi_data_q <= hi_data_d;
            pend_lo_q <= pend_lo_d;
            pend_hi_q <= pend_hi_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
        end
    end

    // pend_lo stays set exactly while the lo word is the one being offered
    always_comb begin
        scrub_req          = busy_q;
        scrub_wr_addr      = pend_lo_q ? lo_addr_q : hi_addr_q;
        scrub_wr_data      = pend_lo_q ? lo_data_q : hi_data_q;
        lsu_ecc_scrub_busy = busy_q;
        lsu_ecc_scrub_cnt  = cnt_q;
        lsu_ecc_scrub_ovf  = ovf_q;
    end

    rvecc_encode u_ecc_enc (
        .din     (scrub_wr_data),
        .ecc_out (scrub_wr_ecc)
    );
endmodule
